// File: rtl/alu_muldiv_seq_if.sv
// Control/ALU bundle for the multiply/divide sequencer.
// The slave side is the sequencer; the master side is control unit plus ALU.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic             div_err;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic             alu_cin;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;

    modport master (
        output start, op_div, opa, opb, alu_y, alu_c,
        input  busy, done, div_err, res_hi, res_lo,
        input  alu_A, alu_B, alu_cin, alu_op
    );

    modport slave (
        input  start, op_div, opa, opb, alu_y, alu_c,
        output busy, done, div_err, res_hi, res_lo,
        output alu_A, alu_B, alu_cin, alu_op
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiply / restoring divide sequencer that borrows the
// shared 16-bit ALU for one ADD or SUB per clock.
module alu_muldiv_seq #(
    parameter int         WIDTH          = 16,
    parameter logic [4:0] OP_ADD         = 5'b00000,
    parameter logic [4:0] OP_SUB         = 5'b00010,
    parameter bit         SUB_C_NOBORROW = 1'b1
) (
    input logic              clk,
    input logic              rst,
    alu_muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] sh;
    logic             nb;
    logic             ge;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            err_q    <= err_d;
        end
    end

    assign last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.op_div)
                        state_d = S_MUL;
                    else if (bus.opb == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // a holds acc/rem, b holds mlr/quo, m holds mcand/dvs
    assign sh = {a_q[WIDTH-2:0], b_q[WIDTH-1]};
    assign nb = SUB_C_NOBORROW ? bus.alu_c : ~bus.alu_c;
    assign ge = a_q[WIDTH-1] | nb;

    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    a_d   = '0;
                    b_d   = bus.op_div ? bus.opa : bus.opb;
                    m_d   = bus.op_div ? bus.opb : bus.opa;
                    if (bus.op_div && bus.opb == '0) begin
                        res_hi_d = bus.opa;
                        res_lo_d = '1;
                        err_d    = 1'b1;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_MUL) begin
                    a_d = {bus.alu_c, bus.alu_y[WIDTH-1:1]};
                    b_d = {bus.alu_y[0], b_q[WIDTH-1:1]};
                end else begin
                    a_d = ge ? bus.alu_y : sh;
                    b_d = {b_q[WIDTH-2:0], ge};
                end
                cnt_d = last ? cnt_q : cnt_q + 1'b1;
                if (last) begin
                    res_hi_d = a_d;
                    res_lo_d = b_d;
                    err_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.alu_A  = '0;
        bus.alu_B  = '0;
        bus.alu_op = OP_ADD;
        case (state_q)
            S_MUL: begin
                bus.busy  = 1'b1;
                bus.alu_A = a_q;
                bus.alu_B = b_q[0] ? m_q : '0;
            end
            S_DIV: begin
                bus.busy   = 1'b1;
                bus.alu_op = OP_SUB;
                bus.alu_A  = sh;
                bus.alu_B  = m_q;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.alu_cin = 1'b0;
    assign bus.res_hi  = res_hi_q;
    assign bus.res_lo  = res_lo_q;
    assign bus.div_err = err_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural ALU model.
// Stimulus pushes expectations; the monitor checks every done pulse.
module tb_alu_muldiv_seq;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_muldiv_seq_if #(.WIDTH(16)) bus ();

    alu_muldiv_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU: ADD and SUB only; SUB carry is the no-borrow flag
    logic [16:0] alu_t;
    always_comb begin
        alu_t     = '0;
        bus.alu_y = '0;
        bus.alu_c = 1'b0;
        if (bus.alu_op == 5'b00010) begin
            bus.alu_y = bus.alu_A - bus.alu_B;
            bus.alu_c = (bus.alu_A >= bus.alu_B);
        end else begin
            alu_t     = {1'b0, bus.alu_A} + {1'b0, bus.alu_B} + {16'd0, bus.alu_cin};
            bus.alu_y = alu_t[15:0];
            bus.alu_c = alu_t[16];
        end
    end

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        err;
        int          due;
        int          busy;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("res_hi", int'(bus.res_hi), int'(e.hi));
                    chk("res_lo", int'(bus.res_lo), int'(e.lo));
                    chk("div_err", int'(bus.div_err), int'(e.err));
                    chk("latency_cycle", cyc, e.due);
                    chk("busy_cycles", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic dv, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] hi, input logic [15:0] lo, input logic err);
        exp_t e;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_div = dv;
        bus.opa    = a;
        bus.opb    = b;
        e.hi   = hi;
        e.lo   = lo;
        e.err  = err;
        e.due  = cyc + (err ? 1 : 17);
        e.busy = err ? 0 : 16;
        sbq.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    task automatic run(input string name, input logic dv, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] hi,
                       input logic [15:0] lo, input logic err);
        issue(dv, a, b, hi, lo, err);
        wait_done(name);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_div_err"}, int'(bus.div_err), 0);
        chk({tag, "_res_hi"}, int'(bus.res_hi), 0);
        chk({tag, "_res_lo"}, int'(bus.res_lo), 0);
        chk({tag, "_alu_A"}, int'(bus.alu_A), 0);
        chk({tag, "_alu_B"}, int'(bus.alu_B), 0);
        chk({tag, "_alu_op"}, int'(bus.alu_op), 0);
        chk({tag, "_alu_cin"}, int'(bus.alu_cin), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op_div = 1'b0;
        bus.opa    = '0;
        bus.opb    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("reset");

        run("mul_5x10", 1'b0, 16'd5, 16'd10, 16'd0, 16'd50, 1'b0);
        run("mul_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
        run("div_15_10", 1'b1, 16'd15, 16'd10, 16'd5, 16'd1, 1'b0);
        run("div_ffff_1", 1'b1, 16'hFFFF, 16'd1, 16'd0, 16'hFFFF, 1'b0);
        run("div_8000_ffff", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
        run("div_by_zero", 1'b1, 16'd1234, 16'd0, 16'd1234, 16'hFFFF, 1'b1);
        run("mul_3x3", 1'b0, 16'd3, 16'd3, 16'd0, 16'd9, 1'b0);

        // starts while busy and in the DONE cycle must be dropped
        issue(1'b0, 16'd7, 16'd6, 16'd0, 16'd42, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_mid_mul", int'(bus.busy), 1);
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
        bus.opa    = 16'd9;
        bus.opb    = 16'd0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("mul_7x6");
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
        bus.opa    = 16'd1;
        bus.opb    = 16'd0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_res_lo", int'(bus.res_lo), 42);
        chk("hold_busy", int'(bus.busy), 0);

        // reset in the middle of a divide aborts it
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
        bus.opa    = 16'd5000;
        bus.opb    = 16'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("abort");

        run("div_100_7", 1'b1, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
